// File: rtl/cursor_report_sched.sv
// cursor_report_sched: integrates signed cursor deltas and emits one clamped
// relative-motion/button report per interval over valid/ready, honoring the safety tier.
module cursor_report_sched #(
    parameter int PERIOD = 50000,
    parameter int ACC_W  = 12,
    parameter int RMAX   = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sample_valid,
    input  logic [7:0] dx_in,
    input  logic [7:0] dy_in,
    input  logic [1:0] tier,
    input  logic       click_req,
    output logic       rpt_valid,
    input  logic       rpt_ready,
    output logic [7:0] rpt_dx,
    output logic [7:0] rpt_dy,
    output logic       rpt_btn,
    output logic [7:0] ovf_cnt
);
    localparam int CW = $clog2(PERIOD);
    localparam logic ACCUM = 1'b0;
    localparam logic SEND  = 1'b1;
    localparam logic signed [ACC_W:0]   SMAX = (ACC_W+1)'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] RLIM = ACC_W'(RMAX);

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic [7:0] d);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W-7){d[7]}}, d};
        return s > SMAX ? ACC_W'(SMAX) : s < -SMAX ? ACC_W'(-SMAX) : s[ACC_W-1:0];
    endfunction

    function automatic logic [7:0] clamp(input logic signed [ACC_W-1:0] a);
        return a > RLIM ? 8'(RMAX) : a < -RLIM ? 8'(-RMAX) : a[7:0];
    endfunction

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    state_q, state_d;
    logic signed [ACC_W-1:0] accx_q, accx_d, accy_q, accy_d;
    logic                    click_pend_q, click_pend_d, release_due_q, release_due_d;
    logic [7:0]              rpt_dx_q, rpt_dx_d, rpt_dy_q, rpt_dy_d, ovf_q, ovf_d;
    logic                    rpt_btn_q, rpt_btn_d;
    logic                    lock, samp, tick, click_e, load;
    logic signed [ACC_W-1:0] accx_e, accy_e;
    logic [7:0]              sx, sy;

    always_comb begin
        lock    = tier >= 2'd2;
        samp    = sample_valid & en & ~lock;
        tick    = cnt_q == CW'(PERIOD - 1);
        // Under lockout the registered accumulators may still hold motion for one cycle; mask it.
        accx_e  = lock ? '0 : accx_q;
        accy_e  = lock ? '0 : accy_q;
        click_e = click_pend_q & ~lock;
        load    = tick & (state_q == ACCUM) & ((accx_e != 0) | (accy_e != 0) | click_e | release_due_q);
        sx      = clamp(accx_e);
        sy      = clamp(accy_e);
        cnt_d   = tick ? '0 : CW'(cnt_q + 1'b1);
        accx_d  = lock ? '0 : sat_add(accx_q - (load ? {{(ACC_W-8){sx[7]}}, sx} : '0), samp ? dx_in : 8'd0);
        accy_d  = lock ? '0 : sat_add(accy_q - (load ? {{(ACC_W-8){sy[7]}}, sy} : '0), samp ? dy_in : 8'd0);
        click_pend_d  = ~lock & (click_req | (click_pend_q & ~load));
        release_due_d = load ? click_e : release_due_q;
        rpt_dx_d  = load ? sx : rpt_dx_q;
        rpt_dy_d  = load ? sy : rpt_dy_q;
        rpt_btn_d = load ? click_e : rpt_btn_q;
        state_d   = state_q == ACCUM ? (load ? SEND : ACCUM) : (rpt_ready ? ACCUM : SEND);
        ovf_d     = (tick & (state_q == SEND) & (ovf_q != 8'hFF)) ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            state_q       <= ACCUM;
            accx_q        <= '0;
            accy_q        <= '0;
            click_pend_q  <= 1'b0;
            release_due_q <= 1'b0;
            rpt_dx_q      <= '0;
            rpt_dy_q      <= '0;
            rpt_btn_q     <= 1'b0;
            ovf_q         <= '0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            accx_q        <= accx_d;
            accy_q        <= accy_d;
            click_pend_q  <= click_pend_d;
            release_due_q <= release_due_d;
            rpt_dx_q      <= rpt_dx_d;
            rpt_dy_q      <= rpt_dy_d;
            rpt_btn_q     <= rpt_btn_d;
            ovf_q         <= ovf_d;
        end
    end

    assign rpt_valid = state_q == SEND;
    assign rpt_dx    = rpt_dx_q;
    assign rpt_dy    = rpt_dy_q;
    assign rpt_btn   = rpt_btn_q;
    assign ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_cursor_report_sched.sv
// tb_cursor_report_sched: directed scenarios with a report scoreboard, PERIOD=8.
module tb_cursor_report_sched;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, sample_valid = 1'b0, click_req = 1'b0, rpt_ready = 1'b1;
    logic [7:0] dx_in = '0, dy_in = '0;
    logic [1:0] tier = '0;
    logic       rpt_valid, rpt_btn;
    logic [7:0] rpt_dx, rpt_dy, ovf_cnt;
    int         passed = 0, total = 0, cyc = 0;
    logic [16:0] q[$];
    logic [16:0] e;

    cursor_report_sched #(.PERIOD(8), .ACC_W(12), .RMAX(127)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid), .dx_in(dx_in), .dy_in(dy_in),
        .tier(tier), .click_req(click_req), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_dx(rpt_dx), .rpt_dy(rpt_dy), .rpt_btn(rpt_btn), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int x, input int y, input logic b);
        q.push_back({8'(x), 8'(y), b});
    endtask

    task automatic step(input logic sv, input logic signed [7:0] x, input logic signed [7:0] y, input logic c);
        sample_valid = sv;
        dx_in = x;
        dy_in = y;
        click_req = c;
        @(posedge clk);
        #1;
        cyc++;
        sample_valid = 1'b0;
        click_req = 1'b0;
    endtask

    task automatic tick_expect(input logic v, input int x, input int y, input logic b);
        do step(1'b0, 8'sd0, 8'sd0, 1'b0); while (cyc % 8 != 0);
        chk("tick_valid", 32'(rpt_valid), 32'(v));
        if (v) begin
            chk("tick_dx", $signed(rpt_dx), x);
            chk("tick_dy", $signed(rpt_dy), y);
            chk("tick_btn", 32'(rpt_btn), 32'(b));
        end
    endtask

    always @(negedge clk) begin
        if (rpt_valid && rpt_ready) begin
            chk("rpt_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_dx", $signed(rpt_dx), $signed(e[16:9]));
                chk("sb_dy", $signed(rpt_dy), $signed(e[8:1]));
                chk("sb_btn", 32'(rpt_btn), 32'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_valid", 32'(rpt_valid), 0);
        chk("rst_dx", 32'(rpt_dx), 0);
        chk("rst_dy", 32'(rpt_dy), 0);
        chk("rst_btn", 32'(rpt_btn), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        repeat (5) step(1'b1, 8'sd20, -8'sd3, 1'b0);
        push(100, -15, 1'b0);
        tick_expect(1'b1, 100, -15, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        repeat (2) step(1'b1, 8'sd100, 8'sd0, 1'b0);
        push(127, 0, 1'b0);
        tick_expect(1'b1, 127, 0, 1'b0);
        push(73, 0, 1'b0);
        tick_expect(1'b1, 73, 0, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        step(1'b0, 8'sd0, 8'sd0, 1'b1);
        push(0, 0, 1'b1);
        tick_expect(1'b1, 0, 0, 1'b1);
        push(0, 0, 1'b0);
        tick_expect(1'b1, 0, 0, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        en = 1'b0;
        repeat (3) step(1'b1, 8'sd50, 8'sd50, 1'b0);
        en = 1'b1;
        tick_expect(1'b0, 0, 0, 1'b0);
        step(1'b1, 8'sd40, 8'sd0, 1'b0);
        tier = 2'd2;
        step(1'b1, 8'sd40, 8'sd0, 1'b1);
        repeat (2) step(1'b1, 8'sd40, 8'sd0, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        tier = 2'd0;
        tick_expect(1'b0, 0, 0, 1'b0);
        step(1'b0, 8'sd0, 8'sd0, 1'b1);
        push(0, 0, 1'b1);
        tick_expect(1'b1, 0, 0, 1'b1);
        tier = 2'd3;
        push(0, 0, 1'b0);
        step(1'b1, 8'sd40, 8'sd0, 1'b1);
        tick_expect(1'b1, 0, 0, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        tier = 2'd0;
        // Backpressure across two ticks while 20 samples of +127 drive the accumulator into saturation.
        rpt_ready = 1'b0;
        push(127, 0, 1'b0);
        repeat (8) step(1'b1, 8'sd127, 8'sd0, 1'b0);
        chk("bp_valid_load", 32'(rpt_valid), 1);
        chk("bp_dx_load", $signed(rpt_dx), 127);
        chk("bp_ovf_load", 32'(ovf_cnt), 0);
        repeat (12) step(1'b1, 8'sd127, 8'sd0, 1'b0);
        chk("bp_valid_mid", 32'(rpt_valid), 1);
        do step(1'b0, 8'sd0, 8'sd0, 1'b0); while (cyc % 8 != 0);
        chk("bp_valid_hold", 32'(rpt_valid), 1);
        chk("bp_dx_hold", $signed(rpt_dx), 127);
        chk("bp_ovf", 32'(ovf_cnt), 2);
        rpt_ready = 1'b1;
        repeat (16) push(127, 0, 1'b0);
        push(15, 0, 1'b0);
        for (int i = 0; i < 17; i++) tick_expect(1'b1, i < 16 ? 127 : 15, 0, 1'b0);
        tick_expect(1'b0, 0, 0, 1'b0);
        chk("ovf_kept", 32'(ovf_cnt), 2);
        rpt_ready = 1'b0;
        step(1'b1, 8'sd5, 8'sd0, 1'b0);
        push(5, 0, 1'b0);
        tick_expect(1'b1, 5, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rpt_valid), 0);
        chk("arst_dx", 32'(rpt_dx), 0);
        chk("arst_dy", 32'(rpt_dy), 0);
        chk("arst_btn", 32'(rpt_btn), 0);
        chk("arst_ovf", 32'(ovf_cnt), 0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        rpt_ready = 1'b1;
        tick_expect(1'b0, 0, 0, 1'b0);
        repeat (3) step(1'b0, 8'sd0, 8'sd0, 1'b0);
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
